// File: rtl/seg_pkg.sv
// +------------------------------------------------------------------+
// | seg_pkg - shared types, hex segment table and decode helper.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    return SEG_HEX[value];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decoder.sv
// +------------------------------------------------------------------+
// | seg_decoder - 4-bit hex to active-high 7-segment lookup.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(hex_i);
  end

endmodule

`default_nettype wire

// File: rtl/seg_mux_driver.sv
// +------------------------------------------------------------------+
// | seg_mux_driver - multiplexed N-digit hex 7-segment scan driver.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 24000,
  parameter int DEAD_CYCLES    = 480,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic                    run_q;
  logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           dig_idx_q, dig_idx_d;
  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] pend_digits_q, act_digits_q;
  logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q;

  logic                    slot_end;
  logic                    frame_end;
  logic                    lit;
  logic                    cur_blank;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_raw;

  // The counter holds at zero on the first edge out of reset so that this
  // edge is slot_cnt=0 of the scan timeline.
  always_comb begin
    slot_end   = run_q && (slot_cnt_q == SLOT_LAST);
    frame_end  = slot_end && (dig_idx_q == IDX_LAST);
    slot_cnt_d = slot_cnt_q;
    dig_idx_d  = dig_idx_q;
    if (run_q) begin
      if (slot_end) begin
        slot_cnt_d = '0;
        dig_idx_d  = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
    end
    state_d = ((DEAD_CYCLES != 0) && (int'(slot_cnt_d) < DEAD_CYCLES)) ? DEAD : ON;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q      <= 1'b0;
      slot_cnt_q <= '0;
      dig_idx_q  <= '0;
      state_q    <= DEAD;
    end else begin
      run_q      <= 1'b1;
      slot_cnt_q <= slot_cnt_d;
      dig_idx_q  <= dig_idx_d;
      state_q    <= state_d;
    end
  end

  // A load coinciding with the frame boundary bypasses pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_digits_q <= '0;
      pend_blank_q  <= '1;
      act_digits_q  <= '0;
      act_blank_q   <= '1;
    end else begin
      if (load_i) begin
        pend_digits_q <= digits_i;
        pend_blank_q  <= blank_i;
      end
      if (frame_end) begin
        act_digits_q <= load_i ? digits_i : pend_digits_q;
        act_blank_q  <= load_i ? blank_i  : pend_blank_q;
      end
    end
  end

  generate
    if (NUM_DIGITS == 1) begin : g_single
      always_comb begin
        cur_digit = act_digits_q[3:0];
        cur_blank = act_blank_q[0];
      end
    end else begin : g_multi
      always_comb begin
        cur_digit = act_digits_q[dig_idx_q*4 +: 4];
        cur_blank = act_blank_q[dig_idx_q];
      end
    end
  endgenerate

  seg_decoder u_dec (
    .hex_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    lit    = run_q && (state_q == ON) && !cur_blank;
    an_sel = '0;
    if (lit) begin
      an_sel[dig_idx_q] = 1'b1;
    end
    seg_raw = lit ? dec_seg : 7'h00;
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    an_d    = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_end;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_mux_driver.sv
// +------------------------------------------------------------------+
// | tb_seg_mux_driver - directed self-checking bench, 2 digits.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_seg_mux_driver;

  logic       clk;
  logic       reset;
  logic [7:0] digits;
  logic [1:0] blank;
  logic       load;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame;

  int compared;
  int mismatched;
  int cyc;
  bit mon_en;

  seg_mux_driver #(
    .NUM_DIGITS     (2),
    .REFRESH_DIV    (8),
    .DEAD_CYCLES    (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digits_i (digits),
    .blank_i  (blank),
    .load_i   (load),
    .seg_o    (seg),
    .an_o     (an),
    .frame_o  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // At most one digit enable may be low at any sample point
  always @(negedge clk) begin
    if (mon_en) begin
      compared++;
      if ($countones(~an) > 1) begin
        mismatched++;
        $display("FAIL onehot_an: an_o=%b, required at most one 0 bit", an);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    load  = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    cyc   = -1;
  endtask

  // 0: off, 1: digit 0 lit, 2: digit 1 lit, for data loaded in frame 1
  function automatic int lit_slot(int c);
    int p;
    if (c < 17) return 0;
    p = (c - 1) % 16;
    if (p >= 2 && p <= 7) return 1;
    if (p >= 10 && p <= 15) return 2;
    return 0;
  endfunction

  task automatic test_reset();
    reset  = 1'b0;
    load   = 1'b0;
    digits = 8'h00;
    blank  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      mon_en = 1'b1;
      compared++;
      if (seg !== 7'h7F || an !== 2'b11 || frame !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold: seg=%h an=%b frame=%b, required seg=7f an=11 frame=0",
                 seg, an, frame);
      end
    end
    reset = 1'b1;
    cyc   = -1;
    for (int c = 0; c <= 33; c++) begin
      tick();
      compared++;
      if (seg !== 7'h7F || an !== 2'b11 || frame !== (c == 16 || c == 32)) begin
        mismatched++;
        $display("FAIL idle_scan cyc %0d: seg=%h an=%b frame=%b, required seg=7f an=11 frame=%0b",
                 cyc, seg, an, frame, (c == 16 || c == 32));
      end
    end
  endtask

  task automatic test_load();
    logic [6:0] es;
    logic [1:0] ea;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      tick();
      case (lit_slot(c))
        1:       begin es = 7'h08; ea = 2'b10; end
        2:       begin es = 7'h30; ea = 2'b01; end
        default: begin es = 7'h7F; ea = 2'b11; end
      endcase
      compared++;
      if (seg !== es || an !== ea || frame !== (c == 16 || c == 32)) begin
        mismatched++;
        $display("FAIL load_3A cyc %0d: seg=%h an=%b frame=%b, required seg=%h an=%b",
                 cyc, seg, an, frame, es, ea);
      end
      if (c == 5) begin digits = 8'h3A; blank = 2'b00; load = 1'b1; end
      if (c == 6) load = 1'b0;
    end
  endtask

  task automatic test_bypass();
    logic [6:0] es;
    logic [1:0] ea;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      tick();
      case (lit_slot(c))
        1:       begin es = 7'h40; ea = 2'b10; end
        2:       begin es = 7'h0E; ea = 2'b01; end
        default: begin es = 7'h7F; ea = 2'b11; end
      endcase
      compared++;
      if (seg !== es || an !== ea) begin
        mismatched++;
        $display("FAIL bypass_F0 cyc %0d: seg=%h an=%b, required seg=%h an=%b",
                 cyc, seg, an, es, ea);
      end
      if (c == 15) begin digits = 8'hF0; blank = 2'b00; load = 1'b1; end
      if (c == 16) load = 1'b0;
    end
  endtask

  task automatic test_blank();
    logic [6:0] es;
    logic [1:0] ea;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      tick();
      if (lit_slot(c) == 1) begin es = 7'h78; ea = 2'b10; end
      else begin es = 7'h7F; ea = 2'b11; end
      compared++;
      if (seg !== es || an !== ea) begin
        mismatched++;
        $display("FAIL blank_57 cyc %0d: seg=%h an=%b, required seg=%h an=%b",
                 cyc, seg, an, es, ea);
      end
      if (c == 3) begin digits = 8'h57; blank = 2'b10; load = 1'b1; end
      if (c == 4) load = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 29; c++) begin
      tick();
      if (c == 2) begin digits = 8'h3A; blank = 2'b00; load = 1'b1; end
      if (c == 3) load = 1'b0;
    end
    compared++;
    if (seg !== 7'h30 || an !== 2'b01) begin
      mismatched++;
      $display("FAIL pre_reset_digit1: seg=%h an=%b, required seg=30 an=01", seg, an);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cyc   = -1;
    compared++;
    if (seg !== 7'h7F || an !== 2'b11 || frame !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: seg=%h an=%b frame=%b, required seg=7f an=11 frame=0",
               seg, an, frame);
    end
    for (int c = 0; c <= 32; c++) begin
      tick();
      compared++;
      if (seg !== 7'h7F || an !== 2'b11 || frame !== (c == 16 || c == 32)) begin
        mismatched++;
        $display("FAIL restart_blank cyc %0d: seg=%h an=%b frame=%b, required seg=7f an=11",
                 cyc, seg, an, frame);
      end
    end
  endtask

  task automatic test_sweep();
    logic [6:0] exp_tab [16];
    exp_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int v = 0; v < 16; v++) begin
      do_reset();
      for (int c = 0; c <= 19; c++) begin
        tick();
        if (c == 2) begin digits = {4'h0, 4'(v)}; blank = 2'b10; load = 1'b1; end
        if (c == 3) load = 1'b0;
      end
      compared++;
      if (seg !== exp_tab[v] || an !== 2'b10) begin
        mismatched++;
        $display("FAIL sweep_%h: seg=%h an=%b, required seg=%h an=10",
                 v[3:0], seg, an, exp_tab[v]);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = -1;
    mon_en     = 1'b0;
    test_reset();
    test_load();
    test_bypass();
    test_blank();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
